out_burst_sched: RTL and testbench
==================================

// Module: out_burst_sched
// PURPOSE
//  Sequences the decompressed-result output stage: pops per-page descriptors (dest addr, length), pulses start/length into
//  the result-buffer output unit, splits the 64B-beat stream into AXI write bursts (AW commands + W handshake gating),
//  checks burst 'last' alignment, and waits for the buffer clean-up before the next page. Sits between the job front-end
//  and the host-memory AXI write master.
// PARAMETERS
//  DESC_DEPTH       4   page-descriptor queue depth (power of 2, >=2)
//  MAX_OUTSTANDING  2   AW bursts issued ahead of their completed W data (1..4)
//  ADDR_W           64  destination address width
// PORTS
//  clk             in   1       single clock
//  rst             in   1       synchronous, active-high reset
//  desc_valid      in   1       descriptor offered
//  desc_ready      out  1       descriptor accepted (queue not full)
//  desc_addr       in   ADDR_W  page dest address; [11:0] ignored (forced 4KB aligned)
//  desc_len        in   32      decompressed page length, bytes
//  buf_start       out  1       1-cycle start pulse to result-buffer output unit
//  buf_len         out  32      length for that start; stable from pulse until done
//  buf_valid       in   1       64B beat available from buffer
//  buf_last        in   1       buffer's burst-last flag for current beat
//  buf_ready       out  1       beat consumed (drives buffer 'ready')
//  buf_cl_finish   in   1       buffer valid-bit clean-up complete
//  aw_valid/aw_ready out/in 1   AXI write-address handshake
//  aw_addr         out  ADDR_W  burst start address
//  aw_len          out  8       beats-1
//  w_valid/w_ready out/in 1     AXI write-data handshake (data/strb routed outside)
//  w_last          out  1       last beat of burst (from internal counter)
//  page_done       out  1       1-cycle pulse per completed page
//  busy            out  1       FSM not IDLE or queue non-empty
//  err_align       out  1       sticky: buf_last disagreed with computed burst end
// BEHAVIOUR
//  Reset: all outputs 0 except desc_ready=1; queue emptied, counters 0, FSM IDLE, err_align cleared. Mid-page reset aborts
//   with no page_done; output unit must be reset alongside.
//  Math: beats=ceil(len/64)=len[31:6]+|len[5:0]; burst k covers beats 64k..min(64k+63,beats-1); aw_addr=base+(k<<12);
//   aw_len=min(64,remaining)-1. Bursts never cross 4KB.
//  FSM: IDLE -(queue non-empty)-> LOAD (pop, latch) -> len==0 ? DONE : START (buf_start=1, 1 cycle) -> RUN
//   -> (all W beats sent and all AW accepted) -> CLEAN -> (buf_cl_finish) -> DONE (page_done=1) -> IDLE. IDLE->LOAD->
//   START min 2 cycles after enqueue.
//  AW: in RUN, aw_valid while bursts remain and outstanding<MAX_OUTSTANDING; held stable until aw_ready.
//  W: buf_ready = w_ready & RUN & credit>0 (credit = AW accepted - bursts whose W completed); w_valid = buf_valid & RUN & credit>0.
//   No combinational path aw_ready->w_valid beyond the credit register. w_last when in-burst beat cnt == aw_len of head burst.
//  Check: on each W handshake, buf_last!=w_last -> err_align=1 (sticky, data still passes).
//  Simultaneous AW accept and W-burst completion in one cycle: credit unchanged. desc enqueue in same cycle as LOAD pop on
//   full queue: pop frees slot next cycle only (desc_ready from registered count).
//  Length 0: no start, no AW/W, page_done 1 cycle after LOAD.
// CONFIGURATION
//  OUT_PERF_CNT_EN defined: adds outputs perf_pages[31:0], perf_beats[31:0], perf_wstall[31:0] (cycles buf_valid&~w_ready
//   in RUN); cleared by rst, saturate at all-ones. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Package out_sched_pkg: beat/burst size constants (64B, 64 beats, 4KB shift), fsm state enum, descriptor struct
//   {addr,len}. One sub-module: out_desc_fifo (synchronous FIFO, DESC_DEPTH, registered count, full/empty).
// TESTING
//  len=4096, addr=0x1000_0000 -> one AW addr 0x1000_0000 len 63, 64 W beats, w_last on 64th, page_done after cl_finish.
//  len=8193 -> AWs at +0x0/+0x1000/+0x2000 with aw_len 63,63,0; 129 beats; err_align stays 0 when buf_last matches.
//  len=0 then len=64 queued -> first: page_done, no buf_start/AW; second: one AW aw_len=0, single beat w_last=1.
//  w_ready toggled 50%, aw_ready held low 20 cycles -> no beat passes before first AW accept; max 2 AW outstanding.
//  4 descriptors back-to-back, DESC_DEPTH=4 -> desc_ready low on 5th, pages complete in order; rst mid-RUN -> outputs idle next cycle.
//  buf_last forced on beat 10 of a 64-beat burst -> err_align=1 sticky until rst.

Source files
------------

// File: rtl/out_sched_pkg.sv
// Shared constants, FSM state encoding and descriptor type for the output burst scheduler.
package out_sched_pkg;

  localparam int BEAT_BYTES  = 64;
  localparam int BURST_BEATS = 64;
  localparam int PAGE_SHIFT  = 12;
  localparam int DESC_ADDR_W = 64;
  localparam int BEAT_CNT_W  = 27;
  localparam int BURST_CNT_W = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_CLEAN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [31:0]            len;
  } desc_t;

  // AXI len field (beats-1) of burst idx for a page of the given beat count.
  function automatic logic [7:0] burst_len(input logic [BEAT_CNT_W-1:0]  beats,
                                           input logic [BURST_CNT_W-1:0] idx);
    logic [BEAT_CNT_W-1:0] rem;
    rem = beats - {idx, 6'b0};
    burst_len = (rem >= BEAT_CNT_W'(BURST_BEATS)) ? 8'd63 : rem[7:0] - 8'd1;
  endfunction

endpackage

// File: rtl/out_desc_fifo.sv
// Page-descriptor FIFO; count is registered so full/empty never see a same-cycle pop.
module out_desc_fifo
  import out_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  desc_t wdata,
  output desc_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  desc_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/out_burst_sched.sv
// Output-stage page sequencer: splits each page into 4KB AXI bursts and gates W beats by AW credit.
// Define OUT_PERF_CNT_EN to add the saturating perf_pages/perf_beats/perf_wstall counters.
//
// state    | meaning
// IDLE     | waiting for a queued descriptor
// LOAD     | pop descriptor, latch base/length, derive beat/burst counts
// START    | one-cycle start pulse to the result-buffer output unit
// RUN      | issue AW bursts and pass W beats under credit
// CLEAN    | all data sent, waiting for buffer valid-bit clean-up
// DONE     | one-cycle page_done
module out_burst_sched
  import out_sched_pkg::*;
#(
  parameter int DESC_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [31:0]       desc_len,
  output logic              buf_start,
  output logic [31:0]       buf_len,
  input  logic              buf_valid,
  input  logic              buf_last,
  output logic              buf_ready,
  input  logic              buf_cl_finish,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last,
  output logic              page_done,
  output logic              busy,
  output logic              err_align
`ifdef OUT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_pages,
  output logic [31:0]       perf_beats,
  output logic [31:0]       perf_wstall
`endif
);

  state_t                 state, state_nx;
  desc_t                  fifo_wdata, fifo_rdata;
  logic                   fifo_full, fifo_empty, fifo_pop, desc_push;
  logic [ADDR_W-1:0]      base_q;
  logic [31:0]            len_q;
  logic [BEAT_CNT_W-1:0]  beats_q, ld_beats;
  logic [BURST_CNT_W-1:0] bursts_q, aw_idx, wb_idx;
  logic [5:0]             wbeat;
  logic [2:0]             credit;
  logic [7:0]             head_len;
  logic                   err_q, in_run, has_credit, aw_fire, w_fire, w_burst_end;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^desc_addr[PAGE_SHIFT-1:0];
  assign desc_ready      = ~fifo_full;
  assign desc_push       = desc_valid & ~fifo_full;
  assign fifo_wdata      = '{addr: DESC_ADDR_W'({desc_addr[ADDR_W-1:PAGE_SHIFT], 12'h000}),
                             len:  desc_len};

  out_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ld_beats = {1'b0, fifo_rdata.len[31:6]} + BEAT_CNT_W'(|fifo_rdata.len[5:0]);

  always_comb begin
    state_nx  = state;
    buf_start = 1'b0;
    page_done = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state)
      ST_IDLE:  if (!fifo_empty) state_nx = ST_LOAD;
      ST_LOAD: begin
        fifo_pop = 1'b1;
        state_nx = (fifo_rdata.len == 32'd0) ? ST_DONE : ST_START;
      end
      ST_START: begin
        buf_start = 1'b1;
        state_nx  = ST_RUN;
      end
      ST_RUN:   if (wb_idx == bursts_q && aw_idx == bursts_q) state_nx = ST_CLEAN;
      ST_CLEAN: if (buf_cl_finish) state_nx = ST_DONE;
      ST_DONE: begin
        page_done = 1'b1;
        state_nx  = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // W only sees the registered credit, so aw_ready never reaches w_valid combinationally.
  assign in_run      = (state == ST_RUN);
  assign has_credit  = (credit != 3'd0);
  assign aw_valid    = in_run & (aw_idx != bursts_q) & (credit < 3'(MAX_OUTSTANDING));
  assign aw_addr     = aw_valid ? base_q + (ADDR_W'(aw_idx) << PAGE_SHIFT) : '0;
  assign aw_len      = aw_valid ? burst_len(beats_q, aw_idx) : 8'd0;
  assign head_len    = burst_len(beats_q, wb_idx);
  assign w_burst_end = ({2'b00, wbeat} == head_len);
  assign w_valid     = buf_valid & in_run & has_credit;
  assign buf_ready   = w_ready & in_run & has_credit;
  assign w_last      = w_valid & w_burst_end;
  assign aw_fire     = aw_valid & aw_ready;
  assign w_fire      = w_valid & w_ready;
  assign buf_len     = len_q;
  assign busy        = (state != ST_IDLE) | ~fifo_empty;
  assign err_align   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      bursts_q <= '0;
      aw_idx   <= '0;
      wb_idx   <= '0;
      wbeat    <= '0;
      credit   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_LOAD) begin
        base_q   <= ADDR_W'(fifo_rdata.addr);
        len_q    <= fifo_rdata.len;
        beats_q  <= ld_beats;
        bursts_q <= ld_beats[BEAT_CNT_W-1:6] + BURST_CNT_W'(|ld_beats[5:0]);
        aw_idx   <= '0;
        wb_idx   <= '0;
        wbeat    <= '0;
        credit   <= '0;
      end
      if (aw_fire) aw_idx <= aw_idx + BURST_CNT_W'(1);
      if (w_fire) begin
        wbeat <= w_burst_end ? 6'd0 : wbeat + 6'd1;
        if (w_burst_end) wb_idx <= wb_idx + BURST_CNT_W'(1);
        if (buf_last != w_burst_end) err_q <= 1'b1;
      end
      case ({aw_fire, w_fire & w_burst_end})
        2'b10:   credit <= credit + 3'd1;
        2'b01:   credit <= credit - 3'd1;
        default: credit <= credit;
      endcase
    end
  end

`ifdef OUT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pages  <= '0;
      perf_beats  <= '0;
      perf_wstall <= '0;
    end else begin
      if (page_done && !(&perf_pages)) perf_pages <= perf_pages + 32'd1;
      if (w_fire && !(&perf_beats)) perf_beats <= perf_beats + 32'd1;
      if (in_run && buf_valid && !w_ready && !(&perf_wstall)) perf_wstall <= perf_wstall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_out_burst_sched.sv
// Randomized bench for out_burst_sched against a page/burst arithmetic reference model.
module tb_out_burst_sched;

  logic        clk;
  logic        rst;
  logic        desc_valid, desc_ready;
  logic [63:0] desc_addr;
  logic [31:0] desc_len;
  logic        buf_start;
  logic [31:0] buf_len;
  logic        buf_valid, buf_last, buf_ready, buf_cl_finish;
  logic        aw_valid, aw_ready;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_valid, w_ready, w_last;
  logic        page_done, busy, err_align;
`ifdef OUT_PERF_CNT_EN
  logic [31:0] perf_pages, perf_beats, perf_wstall;
`endif

  out_burst_sched dut (
    .clk           (clk),
    .rst           (rst),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_addr     (desc_addr),
    .desc_len      (desc_len),
    .buf_start     (buf_start),
    .buf_len       (buf_len),
    .buf_valid     (buf_valid),
    .buf_last      (buf_last),
    .buf_ready     (buf_ready),
    .buf_cl_finish (buf_cl_finish),
    .aw_valid      (aw_valid),
    .aw_ready      (aw_ready),
    .aw_addr       (aw_addr),
    .aw_len        (aw_len),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_last        (w_last),
    .page_done     (page_done),
    .busy          (busy),
    .err_align     (err_align)
`ifdef OUT_PERF_CNT_EN
    ,
    .perf_pages    (perf_pages),
    .perf_beats    (perf_beats),
    .perf_wstall   (perf_wstall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
  } pg_t;

  int     n_chk = 0;
  int     n_fail = 0;
  pg_t    to_send[$];
  pg_t    pages[$];
  int     p_wready = 50, p_awready = 50, p_bufvalid = 70, p_clfin = 50;
  int     aw_block = 0;
  longint err_beat = -1;
  longint aw_k = 0, w_b = 0, wb_done = 0;
  bit     started = 0, exp_err = 0, prev_cl = 0, prev_aw_pend = 0;
  logic [63:0] prev_aw_addr;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint beats_of(input logic [31:0] len);
    return ({32'd0, len} + 64'd63) / 64;
  endfunction

  function automatic bit last_of(input logic [31:0] len, input longint b);
    return (b % 64 == 63) || (b == beats_of(len) - 1);
  endfunction

  task automatic model_clear();
    pages.delete();
    to_send.delete();
    aw_k = 0; w_b = 0; wb_done = 0;
    started = 0; exp_err = 0; prev_aw_pend = 0;
    err_beat = -1;
  endtask

  task automatic monitor();
    pg_t         cur;
    logic [63:0] base;
    longint      bt, nb, rem;
    bit          exp_last;
    if (pages.size() == 0) begin
      if (aw_valid || w_valid || page_done || buf_start)
        check_val("spurious_idle", {aw_valid, w_valid, page_done, buf_start}, 0);
    end else begin
      cur  = pages[0];
      base = cur.addr & ~64'hfff;
      bt   = beats_of(cur.len);
      nb   = (bt + 63) / 64;
      if (buf_start) begin
        check_val("start_once", started, 0);
        check_val("start_nonzero", cur.len != 0, 1);
        check_val("buf_len", buf_len, cur.len);
        started = 1;
      end
      if (prev_aw_pend) begin
        check_val("aw_hold", aw_valid, 1);
        check_val("aw_hold_addr", aw_addr, prev_aw_addr);
      end
      if (aw_valid) begin
        check_val("aw_outstanding", (aw_k - wb_done) < 2, 1);
        check_val("aw_extra", aw_k < nb, 1);
      end
      if (w_valid) begin
        check_val("w_bufvalid", buf_valid, 1);
        check_val("w_credit", aw_k > wb_done, 1);
      end
      if (w_valid || buf_ready)
        check_val("hs_match", w_valid & w_ready, buf_valid & buf_ready);
      if (w_valid && w_ready) begin
        exp_last = last_of(cur.len, w_b);
        check_val("w_before_aw", aw_k > w_b / 64, 1);
        check_val("w_beyond", w_b < bt, 1);
        check_val("w_last", w_last, exp_last);
        if (buf_last != exp_last) exp_err = 1;
        if (exp_last) wb_done++;
        w_b++;
      end
      if (aw_valid && aw_ready) begin
        rem = bt - 64 * aw_k;
        check_val("aw_addr", aw_addr, base + (aw_k << 12));
        check_val("aw_len", aw_len, (rem >= 64 ? 64 : rem) - 1);
        aw_k++;
      end
      if (page_done) begin
        check_val("done_aw_cnt", aw_k, nb);
        check_val("done_beats", w_b, bt);
        check_val("done_started", started, cur.len != 0);
        check_val("done_err_align", err_align, exp_err);
        if (cur.len != 0) begin
          check_val("done_after_cl", prev_cl, 1);
          check_val("buf_len_hold", buf_len, cur.len);
        end
        void'(pages.pop_front());
        aw_k = 0; w_b = 0; wb_done = 0; started = 0;
      end
    end
    prev_aw_pend = aw_valid & ~aw_ready;
    prev_aw_addr = aw_addr;
    if (desc_valid && desc_ready) pages.push_back(to_send.pop_front());
  endtask

  task automatic step();
    logic [31:0] cur_len;
    @(negedge clk);
    desc_valid = (to_send.size() > 0);
    if (desc_valid) begin
      desc_addr = to_send[0].addr;
      desc_len  = to_send[0].len;
    end
    w_ready       = ($urandom_range(99) < p_wready);
    aw_ready      = (aw_block > 0) ? 1'b0 : ($urandom_range(99) < p_awready);
    if (aw_block > 0) aw_block--;
    buf_valid     = ($urandom_range(99) < p_bufvalid);
    buf_cl_finish = ($urandom_range(99) < p_clfin);
    cur_len       = (pages.size() > 0) ? pages[0].len : 32'd0;
    buf_last      = (pages.size() > 0) && (last_of(cur_len, w_b) || w_b == err_beat);
    #1;
    if (!rst) monitor();
    prev_cl = buf_cl_finish;
  endtask

  task automatic send(input logic [63:0] addr, input logic [31:0] len);
    pg_t p;
    p.addr = addr;
    p.len  = len;
    to_send.push_back(p);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (to_send.size() == 0 && pages.size() == 0 && !busy) break;
      step();
    end
    check_val("drain_done", (to_send.size() == 0) && (pages.size() == 0) && !busy, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ctl"}, {desc_ready, busy, aw_valid, w_valid, buf_ready, buf_start, page_done, w_last},
              8'b1000_0000);
    check_val({tag, "_err"}, err_align, 0);
  endtask

  task automatic set_rates(input int wr, input int awr, input int bv, input int cl);
    p_wready = wr; p_awready = awr; p_bufvalid = bv; p_clfin = cl;
  endtask

  initial begin
    rst = 1'b1;
    {desc_valid, buf_valid, buf_last, buf_cl_finish, aw_ready, w_ready} = '0;
    desc_addr = '0;
    desc_len  = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    check_val("reset_buf_len", buf_len, 0);
    check_val("reset_aw_fields", {aw_addr, aw_len}, 0);
    rst = 1'b0;
    model_clear();

    // Single full 4KB page at full rate.
    set_rates(100, 100, 100, 100);
    send(64'h1000_0000, 32'd4096);
    drain(400);

    // Three bursts with a one-beat tail, matching buf_last.
    set_rates(50, 60, 70, 50);
    send(64'h0000_00ab_cdef_1234, 32'd8193);
    drain(2000);

    // Zero-length page followed by a single-beat page.
    send(64'h2000_0000, 32'd0);
    send(64'h3000_0000, 32'd64);
    drain(200);

    // AW stalled at page start: no beat may pass before the first AW is accepted.
    aw_block = 20;
    set_rates(50, 50, 80, 50);
    send(64'h4000_0000, 32'd3 * 4096 + 200);
    drain(3000);

    // Queue fill: stall AW so the first page parks in RUN, then offer five more.
    set_rates(50, 0, 80, 50);
    send(64'h5000_0000, 32'd256);
    repeat (6) step();
    for (int i = 1; i <= 5; i++) send(64'h5000_0000 + 64'(i) * 64'h10_0000, 32'd64 * 32'(i));
    repeat (15) step();
    check_val("full_pending", to_send.size(), 1);
    check_val("full_desc_ready", desc_ready, 0);
    check_val("full_busy", busy, 1);
    p_awready = 60;
    drain(3000);

    // Forced buf_last on beat 10: err_align sets and stays set across the next page.
    set_rates(70, 70, 80, 50);
    err_beat = 10;
    send(64'h6000_0000, 32'd4096);
    drain(800);
    err_beat = -1;
    check_val("err_sticky_set", err_align, 1);
    send(64'h6100_0000, 32'd128);
    drain(200);
    check_val("err_sticky_hold", err_align, 1);

    // Reset in the middle of a page.
    send(64'h7000_0000, 32'd8192);
    for (int i = 0; i < 400 && w_b <= 5; i++) step();
    check_val("mid_run_reached", w_b > 5, 1);
    to_send.delete();
    rst = 1'b1;
    step();
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    model_clear();
    step();
    check_idle_outputs("post_rst");

    // Random pages and random handshake rates.
    for (int n = 0; n < 12; n++) begin
      set_rates($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(20, 100));
      if ($urandom_range(3) == 0) aw_block = $urandom_range(25);
      send({$urandom(), $urandom()}, ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(1, 10000)));
      if ($urandom_range(1) == 1) send({$urandom(), $urandom()}, 32'($urandom_range(1, 700)));
      drain(6000);
    end
    check_val("final_err_align", err_align, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
